ram_stream_reader: RTL and testbench

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_reader_if.sv | 25 ++
 rtl/ram_stream_reader.sv | 145 ++++++++++++++
 tb/tb_ram_stream_reader.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_if.sv
// RAM read port plus AXI-Stream master bundle for ram_stream_reader.
// master = the reader, slave = the RAM/stream environment.
interface ram_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport master (
    output rd_en, rd_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  rd_data, rd_data_valid, m_axis_tready
  );

  modport slave (
    input  rd_en, rd_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output rd_data, rd_data_valid, m_axis_tready
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Streams a burst of RAM words (wrapping address) out on AXI-Stream.
// Credit-limited reads into a 2-entry fall-through FIFO; 1 beat/cycle with tready high.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   length_i,
  output logic                  busy_o,
  output logic                  done_o,
  ram_stream_reader_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = '0;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   issue_left_q, issue_left_d;
  logic [ADDR_WIDTH:0]   beat_left_q, beat_left_d;
  logic                  inflight_q;

  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  logic       push, pop, store, unload, drained, accept, rd_en;
  logic       fifo_empty;
  logic [2:0] occupancy;

  // Only data answering a read we actually issued is accepted.
  assign push       = bus.rd_data_valid & inflight_q;
  assign fifo_empty = (count_q == 2'd0);

  // Fall-through: returning data is presented the same cycle it arrives.
  assign bus.m_axis_tvalid = ~fifo_empty | push;
  assign bus.m_axis_tdata  = !fifo_empty ? fifo_q[rd_ptr_q]
                           : (push ? bus.rd_data : '0);
  assign bus.m_axis_tlast  = bus.m_axis_tvalid & (beat_left_q == LEN_ONE);

  assign pop    = bus.m_axis_tvalid & bus.m_axis_tready;
  assign store  = push & ~(fifo_empty & pop);
  assign unload = pop & ~fifo_empty;

  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
  assign drained   = (state_q == S_DRAIN) && fifo_empty && !inflight_q;
  assign accept    = start_i && ((state_q == S_IDLE) || drained);

  assign busy_o      = (state_q != S_IDLE);
  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = addr_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    beat_left_d  = beat_left_q;
    rd_en        = 1'b0;
    done_o       = 1'b0;

    if (pop) begin
      beat_left_d = beat_left_q - LEN_ONE;
    end

    unique case (state_q)
      S_IDLE: begin
      end
      S_READ: begin
        // Credit: 2 - stored - in flight + popping-now must stay positive.
        if ((issue_left_q != LEN_ZERO) && (occupancy < (3'd2 + {2'b00, pop}))) begin
          rd_en        = 1'b1;
          addr_d       = addr_q + ADDR_ONE;
          issue_left_d = issue_left_q - LEN_ONE;
          if (issue_left_q == LEN_ONE) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drained) begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      addr_d       = base_addr_i;
      issue_left_d = length_i;
      beat_left_d  = length_i;
      state_d      = (length_i == LEN_ZERO) ? S_DRAIN : S_READ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      beat_left_q  <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      beat_left_q  <= beat_left_d;
      inflight_q   <= rd_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (store) begin
        fifo_q[wr_ptr_q] <= bus.rd_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (unload) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({store, unload})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a 1-cycle-latency RAM model (mem[i]=i).
// "Cycle c" is the interval sampled at negedge after the c-th posedge following start.
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] length = '0;
  logic       busy, done;
  logic       spur = 1'b0;

  logic [7:0] mem [256];
  logic [7:0] ram_dat_q = '0;
  logic       ram_vld_q = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  ram_stream_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  ram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .length_i    (length),
    .busy_o      (busy),
    .done_o      (done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_vld_q <= bus.rd_en;
    if (bus.rd_en) ram_dat_q <= mem[bus.rd_addr];
  end
  assign bus.rd_data       = spur ? 8'hEE : ram_dat_q;
  assign bus.rd_data_valid = ram_vld_q | spur;

  task automatic pulse_start(input logic [7:0] b, input logic [8:0] l);
    start = 1'b1; base_addr = b; length = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    repeat (2) @(posedge clk);
    #1;
    got = {busy, done, bus.rd_en, bus.rd_addr, bus.m_axis_tvalid, bus.m_axis_tlast};
    n_cmp++; if (got !== 13'd0) begin n_err++; $display("FAIL reset_ctrl got %h exp 0", got); end
    n_cmp++; if (bus.m_axis_tdata !== 8'h00) begin n_err++; $display("FAIL reset_tdata got %h exp 00", bus.m_axis_tdata); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    logic [7:0] e;
    pulse_start(8'h10, 9'd4);
    for (int c = 1; c <= 8; c++) begin
      n_cmp++; if (bus.rd_en !== (c <= 4)) begin n_err++; $display("FAIL basic_rd_en c=%0d got %b", c, bus.rd_en); end
      if (c <= 4) begin
        e = 8'(16 + c - 1);
        n_cmp++; if (bus.rd_addr !== e) begin n_err++; $display("FAIL basic_rd_addr c=%0d got %h exp %h", c, bus.rd_addr, e); end
      end
      n_cmp++; if (bus.m_axis_tvalid !== (c >= 2 && c <= 5)) begin n_err++; $display("FAIL basic_tvalid c=%0d got %b", c, bus.m_axis_tvalid); end
      if (c >= 2 && c <= 5) begin
        e = 8'(16 + c - 2);
        n_cmp++; if (bus.m_axis_tdata !== e) begin n_err++; $display("FAIL basic_tdata c=%0d got %h exp %h", c, bus.m_axis_tdata, e); end
        n_cmp++; if (bus.m_axis_tlast !== (c == 5)) begin n_err++; $display("FAIL basic_tlast c=%0d got %b", c, bus.m_axis_tlast); end
      end
      n_cmp++; if (done !== (c == 6)) begin n_err++; $display("FAIL basic_done c=%0d got %b", c, done); end
      n_cmp++; if (busy !== (c <= 6)) begin n_err++; $display("FAIL basic_busy c=%0d got %b", c, busy); end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [7:0] addrs [$];
    logic [7:0] beats [$];
    pulse_start(8'hFE, 9'd4);
    for (int c = 1; c <= 8; c++) begin
      if (bus.rd_en) addrs.push_back(bus.rd_addr);
      if (bus.m_axis_tvalid) beats.push_back(bus.m_axis_tdata);
      @(negedge clk);
    end
    n_cmp++; if (addrs.size() != 4 || beats.size() != 4) begin
      n_err++; $display("FAIL wrap_count got %0d/%0d exp 4/4", addrs.size(), beats.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (addrs[i] !== exp_a[i]) begin n_err++; $display("FAIL wrap_addr i=%0d got %h exp %h", i, addrs[i], exp_a[i]); end
        n_cmp++; if (beats[i] !== exp_a[i]) begin n_err++; $display("FAIL wrap_data i=%0d got %h exp %h", i, beats[i], exp_a[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat = 4'b1001;
    logic [7:0] beats [$];
    logic       lasts [$];
    int nret = 0, npop = 0, ndone = 0, last_hs = -1, done_c = -1;
    logic prev_stall = 1'b0, prev_l = 1'b0;
    logic [7:0] prev_d = '0;
    pulse_start(8'h40, 9'd8);
    for (int c = 1; c <= 40; c++) begin
      bus.m_axis_tready = pat[(c - 1) % 4];
      n_cmp++; if (nret - npop > 2) begin n_err++; $display("FAIL bp_depth c=%0d got %0d exp <=2", c, nret - npop); end
      if (prev_stall) begin
        n_cmp++;
        if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== prev_d || bus.m_axis_tlast !== prev_l) begin
          n_err++; $display("FAIL bp_stable c=%0d got %b/%h/%b exp 1/%h/%b", c, bus.m_axis_tvalid,
                            bus.m_axis_tdata, bus.m_axis_tlast, prev_d, prev_l);
        end
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        beats.push_back(bus.m_axis_tdata); lasts.push_back(bus.m_axis_tlast);
        npop++; last_hs = c;
      end
      if (bus.rd_data_valid) nret++;
      if (done) begin ndone++; done_c = c; end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_d = bus.m_axis_tdata; prev_l = bus.m_axis_tlast;
      @(negedge clk);
    end
    bus.m_axis_tready = 1'b1;
    n_cmp++; if (beats.size() != 8) begin n_err++; $display("FAIL bp_count got %0d exp 8", beats.size()); end
    for (int i = 0; i < beats.size() && i < 8; i++) begin
      n_cmp++; if (beats[i] !== 8'(64 + i) || lasts[i] !== (i == 7)) begin
        n_err++; $display("FAIL bp_beat i=%0d got %h/%b exp %h/%b", i, beats[i], lasts[i], 8'(64 + i), (i == 7));
      end
    end
    n_cmp++; if (ndone != 1 || done_c != last_hs + 1) begin
      n_err++; $display("FAIL bp_done got n=%0d at %0d exp n=1 at %0d", ndone, done_c, last_hs + 1);
    end
  endtask

  task automatic test_len0();
    pulse_start(8'h33, 9'd0);
    n_cmp++; if ({done, busy, bus.rd_en, bus.m_axis_tvalid} !== 4'b1100) begin
      n_err++; $display("FAIL len0_c1 got %b exp 1100", {done, busy, bus.rd_en, bus.m_axis_tvalid});
    end
    @(negedge clk);
    n_cmp++; if ({done, busy, bus.rd_en, bus.m_axis_tvalid} !== 4'b0000) begin
      n_err++; $display("FAIL len0_c2 got %b exp 0000", {done, busy, bus.rd_en, bus.m_axis_tvalid});
    end
  endtask

  task automatic test_len256();
    int hits [256];
    int bad_addr = 0, bad_data = 0, nbeat = 0, last_c = -1, done_c = -1;
    for (int i = 0; i < 256; i++) hits[i] = 0;
    pulse_start(8'h37, 9'd256);
    for (int c = 1; c <= 262; c++) begin
      if (bus.rd_en) hits[bus.rd_addr]++;
      if (bus.m_axis_tvalid) begin
        if (bus.m_axis_tdata !== 8'(8'h37 + nbeat)) bad_data++;
        if (bus.m_axis_tlast) last_c = c;
        nbeat++;
      end
      if (done) done_c = c;
      @(negedge clk);
    end
    for (int i = 0; i < 256; i++) if (hits[i] != 1) bad_addr++;
    n_cmp++; if (bad_addr != 0) begin n_err++; $display("FAIL len256_addr got %0d bad exp 0", bad_addr); end
    n_cmp++; if (nbeat != 256 || bad_data != 0) begin n_err++; $display("FAIL len256_data got %0d beats %0d bad exp 256/0", nbeat, bad_data); end
    n_cmp++; if (last_c != 257 || done_c != 258) begin n_err++; $display("FAIL len256_timing got last %0d done %0d exp 257/258", last_c, done_c); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] beats [$];
    int done_c = -1;
    pulse_start(8'h20, 9'd6);
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin start = 1'b1; base_addr = 8'h80; length = 9'd2; end
      else start = 1'b0;
      if (bus.m_axis_tvalid) beats.push_back(bus.m_axis_tdata);
      if (done) begin
        done_c = c; start = 1'b1; base_addr = 8'h90; length = 9'd3;
        break;
      end
      @(negedge clk);
    end
    n_cmp++; if (done_c != 8) begin n_err++; $display("FAIL b2b_done1 got %0d exp 8", done_c); end
    n_cmp++; if (beats.size() != 6) begin n_err++; $display("FAIL b2b_count1 got %0d exp 6", beats.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++; if (beats[i] !== 8'(32 + i)) begin n_err++; $display("FAIL b2b_data1 i=%0d got %h exp %h", i, beats[i], 8'(32 + i)); end
      end
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if ({bus.rd_en, bus.rd_addr, busy} !== {1'b1, 8'h90, 1'b1}) begin
      n_err++; $display("FAIL b2b_restart got %b/%h/%b exp 1/90/1", bus.rd_en, bus.rd_addr, busy);
    end
    beats.delete(); done_c = -1;
    for (int c = 1; c <= 8; c++) begin
      if (bus.m_axis_tvalid) beats.push_back(bus.m_axis_tdata);
      if (done) done_c = c;
      @(negedge clk);
    end
    n_cmp++; if (beats.size() != 3 || beats[0] !== 8'h90 || beats[2] !== 8'h92 || done_c != 5) begin
      n_err++; $display("FAIL b2b_second got %0d beats, done %0d exp 3 beats 90..92, done 5", beats.size(), done_c);
    end
  endtask

  task automatic test_spurious();
    spur = 1'b1;
    #1;
    n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL spur_tvalid got %b exp 0", bus.m_axis_tvalid); end
    @(negedge clk);
    spur = 1'b0;
    n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL spur_after got %b exp 0", bus.m_axis_tvalid); end
    pulse_start(8'h05, 9'd1);
    @(negedge clk);
    n_cmp++; if ({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast} !== {1'b1, 8'h05, 1'b1}) begin
      n_err++; $display("FAIL len1_beat got %b/%h/%b exp 1/05/1", bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast);
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL len1_done got %b exp 1", done); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int npop = 0, done_c = -1;
    logic [7:0] beats [$];
    logic [8:0] lasts = '0;
    pulse_start(8'h50, 9'd8);
    for (int c = 1; c <= 20 && npop < 3; c++) begin
      if (bus.m_axis_tvalid && bus.m_axis_tready) npop++;
      if (npop < 3) @(negedge clk);
    end
    n_cmp++; if (npop != 3) begin n_err++; $display("FAIL rstmid_timeout got %0d beats exp 3", npop); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, bus.rd_en, bus.rd_addr, bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata} !== 21'd0) begin
      n_err++; $display("FAIL rstmid_outputs got %b/%b/%b/%h/%b/%b/%h exp all 0", busy, done, bus.rd_en,
                        bus.rd_addr, bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL rstmid_nodone c=%0d got %b exp 00", c, {done, busy}); end
    end
    pulse_start(8'h60, 9'd2);
    for (int c = 1; c <= 6; c++) begin
      if (bus.m_axis_tvalid) begin beats.push_back(bus.m_axis_tdata); lasts[c] = bus.m_axis_tlast; end
      if (done) done_c = c;
      @(negedge clk);
    end
    n_cmp++; if (beats.size() != 2 || beats[0] !== 8'h60 || beats[1] !== 8'h61 || lasts !== 9'b000001000 || done_c != 4) begin
      n_err++; $display("FAIL rstmid_fresh got %0d beats lasts %b done %0d exp 2 beats 60,61 lasts 000001000 done 4",
                        beats.size(), lasts, done_c);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    bus.m_axis_tready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0();
    test_len256();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
